// File: rtl/algo_nrnw_1r1w_wq.sv
// N-read / M-write memory: NUMRDPT replicated 1R1W SRAMs fed by a write queue with read forwarding.
// Optional: define ALGO_WQ_PARITY_EN to store even parity in the SRAM word MSB and report rd_serr.

module algo_wq_rd_lane #(
  parameter int WIDTH      = 32,
  parameter int BITADDR    = 13,
  parameter int QDEPTH     = 8,
  parameter int BITQPTR    = 3,
  parameter int SRAM_DELAY = 2,
  parameter int MEMWDTH    = 32
)(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue,
  input  logic [BITADDR-1:0]                adr,
  input  logic [QDEPTH-1:0][BITADDR-1:0]    q_adr,
  input  logic [QDEPTH-1:0][WIDTH-1:0]      q_dat,
  input  logic [BITQPTR-1:0]                q_head,
  input  logic [BITQPTR:0]                  q_cnt,
  input  logic [MEMWDTH-1:0]                mem_dout,
  output logic                              rd_vld,
  output logic [WIDTH-1:0]                  rd_dout,
  output logic                              rd_fwrd,
  output logic                              rd_serr
);
  localparam int STAGES = SRAM_DELAY - 1;

  logic                   hit;
  logic [WIDTH-1:0]       hit_dat;
  logic [STAGES:0]        vld_pipe;
  logic [STAGES:0]        fwd_pipe;
  logic [STAGES:0][WIDTH-1:0] dat_pipe;
  logic [WIDTH-1:0]       hold;
  logic                   fwd;

  // Walk from head (oldest) to tail so the newest matching entry wins.
  always_comb begin
    hit     = 1'b0;
    hit_dat = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      if (((BITQPTR+1)'(k) < q_cnt) && (q_adr[q_head + BITQPTR'(k)] == adr)) begin
        hit     = 1'b1;
        hit_dat = q_dat[q_head + BITQPTR'(k)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      fwd_pipe <= '0;
      dat_pipe <= '0;
      hold     <= '0;
    end else begin
      vld_pipe[0] <= issue;
      fwd_pipe[0] <= issue & hit;
      dat_pipe[0] <= hit_dat;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        fwd_pipe[s] <= fwd_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
      if (rd_vld) hold <= rd_dout;
    end
  end

  assign fwd     = fwd_pipe[STAGES];
  assign rd_vld  = vld_pipe[STAGES];
  assign rd_fwrd = rd_vld & fwd;
  assign rd_dout = rd_vld ? (fwd ? dat_pipe[STAGES] : mem_dout[WIDTH-1:0]) : hold;

`ifdef ALGO_WQ_PARITY_EN
  assign rd_serr = rd_vld & ~fwd & (^mem_dout);
`else
  assign rd_serr = 1'b0;
`endif
endmodule

module algo_nrnw_1r1w_wq #(
  parameter int WIDTH      = 32,
  parameter int NUMRDPT    = 2,
  parameter int NUMWRPT    = 3,
  parameter int NUMADDR    = 8192,
  parameter int BITADDR    = 13,
  parameter int QDEPTH     = 8,
  parameter int BITQPTR    = 3,
  parameter int SRAM_DELAY = 2
`ifdef ALGO_WQ_PARITY_EN
  , localparam int MEMWDTH = WIDTH + 1
`else
  , localparam int MEMWDTH = WIDTH
`endif
)(
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready,
  input  logic [NUMWRPT-1:0]           write,
  input  logic [NUMWRPT*BITADDR-1:0]   wr_adr,
  input  logic [NUMWRPT*WIDTH-1:0]     din,
  output logic                         wr_rdy,
  output logic                         wr_drop,
  input  logic [NUMRDPT-1:0]           read,
  input  logic [NUMRDPT*BITADDR-1:0]   rd_adr,
  output logic [NUMRDPT-1:0]           rd_vld,
  output logic [NUMRDPT*WIDTH-1:0]     rd_dout,
  output logic [NUMRDPT-1:0]           rd_fwrd,
  output logic [NUMRDPT-1:0]           rd_serr,
  output logic                         t1_writeA,
  output logic [BITADDR-1:0]           t1_addrA,
  output logic [MEMWDTH-1:0]           t1_dinA,
  output logic [NUMRDPT-1:0]           t1_readB,
  output logic [NUMRDPT*BITADDR-1:0]   t1_addrB,
  input  logic [NUMRDPT*MEMWDTH-1:0]   t1_doutB
);
  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                          state, state_nxt;
  logic [BITADDR-1:0]              init_cnt;
  logic [QDEPTH-1:0][BITADDR-1:0]  q_adr;
  logic [QDEPTH-1:0][WIDTH-1:0]    q_dat;
  logic [BITQPTR-1:0]              q_head, q_tail;
  logic [BITQPTR:0]                q_cnt;
  logic [NUMWRPT-1:0][BITADDR-1:0] wa;
  logic [NUMWRPT-1:0][WIDTH-1:0]   wd;
  logic [NUMWRPT-1:0][BITQPTR-1:0] enq_slot;
  logic [BITQPTR:0]                enq_cnt;
  logic                            deq;
  logic [WIDTH-1:0]                wdat;
  logic [NUMRDPT-1:0][BITADDR-1:0] ra, rao;
  logic [NUMRDPT-1:0][MEMWDTH-1:0] mdo;
  logic [NUMRDPT-1:0][WIDTH-1:0]   rdo;

  assign wa       = wr_adr;
  assign wd       = din;
  assign ra       = rd_adr;
  assign mdo      = t1_doutB;
  assign t1_addrB = rao;
  assign rd_dout  = rdo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && init_cnt == BITADDR'(NUMADDR-1)) state_nxt = S_RUN;
  end

  assign ready  = (state == S_RUN);
  // Free-slot check uses registered occupancy only; same-cycle drain is not credited.
  assign wr_rdy = ready && (((BITQPTR+1)'(QDEPTH) - q_cnt) >= (BITQPTR+1)'(NUMWRPT));
  assign deq    = ready && (q_cnt != '0);

  // Asserted ports take consecutive slots from tail in ascending port order.
  always_comb begin
    enq_cnt  = '0;
    enq_slot = '0;
    for (int p = 0; p < NUMWRPT; p++) begin
      enq_slot[p] = q_tail + enq_cnt[BITQPTR-1:0];
      if (write[p]) enq_cnt = enq_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_head  <= '0;
      q_tail  <= '0;
      q_cnt   <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= ready & ~wr_rdy & (|write);
      if (wr_rdy) q_tail <= q_tail + enq_cnt[BITQPTR-1:0];
      if (deq)    q_head <= q_head + 1'b1;
      q_cnt <= q_cnt + (wr_rdy ? enq_cnt : '0) - {{BITQPTR{1'b0}}, deq};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_rdy) begin
      for (int p = 0; p < NUMWRPT; p++) begin
        if (write[p]) begin
          q_adr[enq_slot[p]] <= wa[p];
          q_dat[enq_slot[p]] <= wd[p];
        end
      end
    end
  end

  // rst gating keeps the physical write port quiet while reset is held.
  always_comb begin
    t1_writeA = 1'b0;
    t1_addrA  = '0;
    wdat      = '0;
    if (state == S_INIT && !rst) begin
      t1_writeA = 1'b1;
      t1_addrA  = init_cnt;
    end else if (deq) begin
      t1_writeA = 1'b1;
      t1_addrA  = q_adr[q_head];
      wdat      = q_dat[q_head];
    end
  end

`ifdef ALGO_WQ_PARITY_EN
  assign t1_dinA = {^wdat, wdat};
`else
  assign t1_dinA = wdat;
`endif

  for (genvar i = 0; i < NUMRDPT; i++) begin : g_lane
    assign t1_readB[i] = read[i] & ready;
    assign rao[i]      = t1_readB[i] ? ra[i] : '0;

    algo_wq_rd_lane #(
      .WIDTH(WIDTH), .BITADDR(BITADDR), .QDEPTH(QDEPTH), .BITQPTR(BITQPTR),
      .SRAM_DELAY(SRAM_DELAY), .MEMWDTH(MEMWDTH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .issue    (t1_readB[i]),
      .adr      (ra[i]),
      .q_adr    (q_adr),
      .q_dat    (q_dat),
      .q_head   (q_head),
      .q_cnt    (q_cnt),
      .mem_dout (mdo[i]),
      .rd_vld   (rd_vld[i]),
      .rd_dout  (rdo[i]),
      .rd_fwrd  (rd_fwrd[i]),
      .rd_serr  (rd_serr[i])
    );
  end
endmodule
